// File: rtl/kim_fifo_pkg.sv
// ---------------------------------------------------------------------------
// kim_fifo_pkg
// Shared encodings for the FIFO control stage and the skid buffer that sits
// behind it. State codes double as occupancy so level decode is trivial.
//   state_e      : S_EMPTY / S_BUSY / S_FULL (2'b11 unused, treated as empty)
//   LVL_*        : occupancy encodings presented on level outputs
//   state_level(): maps a state code to its occupancy
// ---------------------------------------------------------------------------
package kim_fifo_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_BUSY  = 2'b01,
        S_FULL  = 2'b10
    } state_e;

    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_ONE   = 2'd1;
    localparam logic [1:0] LVL_TWO   = 2'd2;

    function automatic logic [1:0] state_level(input state_e s);
        case (s)
            S_BUSY:  return LVL_ONE;
            S_FULL:  return LVL_TWO;
            default: return LVL_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/kim_sat_counter.sv
// ---------------------------------------------------------------------------
// kim_sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears the count
//   inc   : increment this cycle
//   clr   : synchronous clear (has priority over inc)
//   count : current count
// ---------------------------------------------------------------------------
module kim_sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != {WIDTH{1'b1}}))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/kim_skid_buffer.sv
// ---------------------------------------------------------------------------
// kim_skid_buffer
// Two-entry register slice behind the FIFO control stage. All outputs
// (s_ready, m_valid, m_data) come straight from flops, cutting the ready
// path and the FIFO empty-bypass data path while still sustaining one
// transfer per cycle.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   s_valid   : upstream valid          s_ready : registered accept
//   s_data    : upstream payload
//   m_valid   : registered out valid    m_ready : downstream accept
//   m_data    : registered payload
//   level     : occupancy 0..2
//   stall_cnt : saturating count of m_valid && !m_ready cycles, present
//               only when KIM_SKID_STALL_CNT_EN is defined
// ---------------------------------------------------------------------------
module kim_skid_buffer
    import kim_fifo_pkg::*;
#(
    parameter int unsigned DATA_LENGTH = 32,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_LENGTH-1:0] s_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_LENGTH-1:0] m_data,
    output logic [1:0]             level
`ifdef KIM_SKID_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]   stall_cnt
`endif
);

    state_e                 state_q, state_d;
    logic [DATA_LENGTH-1:0] out_q, out_d;
    logic [DATA_LENGTH-1:0] skid_q, skid_d;
    logic                   m_valid_q, m_valid_d;
    logic                   s_ready_q, s_ready_d;
    logic                   in_hs, out_hs;

    assign in_hs  = s_valid && s_ready_q;
    assign out_hs = m_valid_q && m_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            S_EMPTY: begin
                if (in_hs) begin
                    out_d   = s_data;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (in_hs && out_hs) begin
                    out_d = s_data;
                end else if (in_hs) begin
                    // Downstream stalled: park the new word behind out_q.
                    skid_d  = s_data;
                    state_d = S_FULL;
                end else if (out_hs) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                // s_ready is low here, so only the drain side can move.
                if (out_hs) begin
                    out_d   = skid_q;
                    state_d = S_BUSY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Handshake flags are decoded from the next state so they change on the
    // same edge as the data they qualify.
    assign m_valid_d = (state_d == S_BUSY) || (state_d == S_FULL);
    assign s_ready_d = (state_d != S_FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            skid_q    <= skid_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = out_q;
    assign level   = state_level(state_q);

`ifdef KIM_SKID_STALL_CNT_EN
    kim_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst),
        .inc   (m_valid_q && !m_ready),
        .clr   (1'b0),
        .count (stall_cnt)
    );
`else
    logic [CNT_WIDTH-1:0] unused_stall_cnt;
    assign unused_stall_cnt = '0;
`endif

endmodule
